// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_fetch_stage : PC ownership, imem addressing and IF/ID register
// Revision 1.0
// ---------------------------------------------------------------------------
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [31:0]            imem_address,
  input  logic [31:0]            imem_instruction,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   redirect,
  input  logic [31:0]            redirect_target,
  input  logic                   halt,
  output logic                   ifid_valid,
  output logic [31:0]            ifid_instruction,
  output logic [31:0]            ifid_pc,
  output logic [31:0]            ifid_pc_plus4,
  output logic                   misaligned,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        target_misaligned;

  assign imem_address      = pc;
  assign halted            = (state == ST_HALTED);
  assign target_misaligned = |redirect_target[1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= ST_RUN;
      pc               <= RESET_PC;
      ifid_valid       <= 1'b0;
      ifid_instruction <= 32'h0;
      ifid_pc          <= 32'h0;
      ifid_pc_plus4    <= 32'h0;
      misaligned       <= 1'b0;
      fetch_count      <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (redirect && target_misaligned) begin
            state      <= ST_FAULT;
            misaligned <= 1'b1;
            ifid_valid <= 1'b0;
          end else if (redirect) begin
            // Wrong-path word in flight is dropped; target fetched next cycle.
            pc               <= redirect_target;
            ifid_valid       <= 1'b0;
            ifid_instruction <= 32'h0;
          end else if (halt) begin
            state      <= ST_HALTED;
            ifid_valid <= 1'b0;
          end else if (flush) begin
            ifid_valid       <= 1'b0;
            ifid_instruction <= 32'h0;
          end else if (!stall) begin
            ifid_instruction <= imem_instruction;
            ifid_pc          <= pc;
            ifid_pc_plus4    <= pc + 32'd4;
            ifid_valid       <= 1'b1;
            pc               <= pc + 32'd4;
            fetch_count      <= fetch_count + COUNT_WIDTH'(1);
          end
        end
        default: begin
          // HALTED and FAULT freeze everything until reset.
          ifid_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instruction_fetch_stage : table vectors, corner sequences, random vs model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_instruction_fetch_stage;

  localparam int CW = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   imem_address;
  logic [31:0]   imem_instruction;
  logic          stall = 1'b0, flush = 1'b0, redirect = 1'b0, halt = 1'b0;
  logic [31:0]   redirect_target = 32'h0;
  logic          ifid_valid;
  logic [31:0]   ifid_instruction, ifid_pc, ifid_pc_plus4;
  logic          misaligned, halted;
  logic [CW-1:0] fetch_count;

  int tests = 0;
  int failed = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0274_4820;
      32'h0000_0004: mem_word = 32'h0257_9822;
      32'h0000_0008: mem_word = 32'h1210_000C;
      32'h0000_0020: mem_word = 32'h8ED2_0008;
      default:       mem_word = {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
    endcase
  endfunction

  assign imem_instruction = mem_word(imem_address);

  instruction_fetch_stage #(.RESET_PC(32'h0), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .imem_address(imem_address), .imem_instruction(imem_instruction),
    .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_target(redirect_target), .halt(halt),
    .ifid_valid(ifid_valid), .ifid_instruction(ifid_instruction),
    .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
    .misaligned(misaligned), .halted(halted), .fetch_count(fetch_count)
  );

  // Reference model: the architectural effect of each edge.
  logic        m_halted, m_fault, m_mis, m_valid;
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4;
  int          m_cnt;

  task automatic model_step(input logic rs, st, fl, rd, hl, input logic [31:0] tgt);
    if (rs) begin
      m_halted = 0; m_fault = 0; m_mis = 0; m_valid = 0;
      m_pc = 0; m_instr = 0; m_ifpc = 0; m_ifpc4 = 0; m_cnt = 0;
    end else if (m_halted || m_fault) begin
      m_valid = 0;
    end else if (rd && tgt[1:0] != 2'b00) begin
      m_fault = 1; m_mis = 1; m_valid = 0;
    end else if (rd) begin
      m_pc = tgt; m_valid = 0; m_instr = 0;
    end else if (hl) begin
      m_halted = 1; m_valid = 0;
    end else if (fl) begin
      m_valid = 0; m_instr = 0;
    end else if (!st) begin
      m_instr = mem_word(m_pc); m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
      m_valid = 1; m_pc = m_pc + 32'd4; m_cnt = (m_cnt + 1) % (1 << CW);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic rs, st, fl, rd, hl, input logic [31:0] tgt);
    reset = rs; stall = st; flush = fl; redirect = rd; halt = hl; redirect_target = tgt;
    @(posedge clock);
    model_step(rs, st, fl, rd, hl, tgt);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".addr"},  imem_address, m_pc);
    chk({tag, ".valid"}, 32'(ifid_valid), 32'(m_valid));
    chk({tag, ".instr"}, ifid_instruction, m_instr);
    chk({tag, ".pc"},    ifid_pc, m_ifpc);
    chk({tag, ".pc4"},   ifid_pc_plus4, m_ifpc4);
    chk({tag, ".mis"},   32'(misaligned), 32'(m_mis));
    chk({tag, ".halt"},  32'(halted), 32'(m_halted));
    chk({tag, ".cnt"},   32'(fetch_count), 32'(m_cnt));
  endtask

  typedef struct {
    logic        st, fl, rd;
    logic [31:0] tgt;
    logic        e_valid;
    logic [31:0] e_instr, e_pc, e_addr;
    int          e_cnt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{0, 0, 0, 32'h0,  1, 32'h0274_4820, 32'h00, 32'h04, 1};
    vecs[1] = '{1, 0, 0, 32'h0,  1, 32'h0274_4820, 32'h00, 32'h04, 1};
    vecs[2] = '{1, 0, 0, 32'h0,  1, 32'h0274_4820, 32'h00, 32'h04, 1};
    vecs[3] = '{0, 0, 0, 32'h0,  1, 32'h0257_9822, 32'h04, 32'h08, 2};
    vecs[4] = '{0, 0, 0, 32'h0,  1, 32'h1210_000C, 32'h08, 32'h0C, 3};
    vecs[5] = '{1, 0, 1, 32'h20, 0, 32'h0,         32'h08, 32'h20, 3};
    vecs[6] = '{0, 0, 0, 32'h0,  1, 32'h8ED2_0008, 32'h20, 32'h24, 4};
    vecs[7] = '{1, 1, 0, 32'h0,  0, 32'h0,         32'h20, 32'h24, 4};
    vecs[8] = '{0, 0, 0, 32'h0,  1, mem_word(32'h24), 32'h24, 32'h28, 5};

    @(negedge clock);
    apply(1, 0, 0, 0, 0, 0);
    chk("rst.addr", imem_address, 32'h0);
    chk("rst.valid", 32'(ifid_valid), 32'h0);
    chk("rst.instr", ifid_instruction, 32'h0);
    chk("rst.pc", ifid_pc, 32'h0);
    chk("rst.pc4", ifid_pc_plus4, 32'h0);
    chk("rst.mis", 32'(misaligned), 32'h0);
    chk("rst.halt", 32'(halted), 32'h0);
    chk("rst.cnt", 32'(fetch_count), 32'h0);

    for (int i = 0; i < 9; i++) begin
      apply(0, vecs[i].st, vecs[i].fl, vecs[i].rd, 0, vecs[i].tgt);
      chk($sformatf("vec%0d.valid", i), 32'(ifid_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.instr", i), ifid_instruction, vecs[i].e_instr);
      chk($sformatf("vec%0d.pc", i), ifid_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d.pc4", i), ifid_pc_plus4, vecs[i].e_pc + 32'd4);
      chk($sformatf("vec%0d.addr", i), imem_address, vecs[i].e_addr);
      chk($sformatf("vec%0d.cnt", i), 32'(fetch_count), 32'(vecs[i].e_cnt));
    end

    // Misaligned redirect: sticky fault until reset.
    apply(1, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 0, 32'h26);
    chk("mis.flag", 32'(misaligned), 32'h1);
    chk("mis.valid", 32'(ifid_valid), 32'h0);
    chk("mis.addr", imem_address, 32'h8);
    apply(0, 0, 0, 1, 0, 32'h40);
    apply(0, 0, 0, 0, 1, 32'h0);
    apply(0, 0, 0, 0, 0, 32'h0);
    chk("mis.hold.flag", 32'(misaligned), 32'h1);
    chk("mis.hold.valid", 32'(ifid_valid), 32'h0);
    chk("mis.hold.addr", imem_address, 32'h8);
    chk("mis.hold.halted", 32'(halted), 32'h0);
    chk("mis.hold.cnt", 32'(fetch_count), 32'h2);
    apply(1, 0, 0, 0, 0, 0);
    chk("mis.rst.flag", 32'(misaligned), 32'h0);
    chk("mis.rst.addr", imem_address, 32'h0);

    // Halt at PC 0x10, later redirect ignored.
    for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 0);
    chk("halt.flag", 32'(halted), 32'h1);
    chk("halt.valid", 32'(ifid_valid), 32'h0);
    chk("halt.addr", imem_address, 32'h10);
    apply(0, 0, 0, 1, 0, 32'h40);
    apply(0, 0, 0, 0, 0, 0);
    chk("halt.frozen.addr", imem_address, 32'h10);
    chk("halt.frozen.flag", 32'(halted), 32'h1);
    apply(1, 0, 0, 0, 0, 0);
    chk("halt.rst.flag", 32'(halted), 32'h0);
    apply(0, 0, 0, 0, 0, 0);
    chk("halt.rst.valid", 32'(ifid_valid), 32'h1);

    // halt+redirect: redirect wins. Then PC wrap at top of address space.
    apply(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    chk("hr.halted", 32'(halted), 32'h0);
    chk("hr.addr", imem_address, 32'hFFFF_FFFC);
    apply(0, 0, 0, 0, 0, 0);
    chk("wrap.pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wrap.pc4", ifid_pc_plus4, 32'h0);
    chk("wrap.addr", imem_address, 32'h0);
    chk("wrap.instr", ifid_instruction, mem_word(32'hFFFF_FFFC));

    // Randomized traffic against the reference model (model already in sync).
    for (int i = 0; i < 600; i++) begin
      logic rs, st, fl, rd, hl;
      logic [31:0] tgt;
      rs  = ($urandom_range(0, 99) < 3);
      st  = ($urandom_range(0, 99) < 30);
      fl  = ($urandom_range(0, 99) < 10);
      rd  = ($urandom_range(0, 99) < 8);
      hl  = ($urandom_range(0, 99) < 2);
      case ($urandom_range(0, 7))
        0:       tgt = 32'hFFFF_FFFC;
        1:       tgt = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        default: tgt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      endcase
      apply(rs, st, fl, rd, hl, tgt);
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
